// File: rtl/simon_sequencer_if.sv
// Player/engine signal bundle for simon_sequencer: button decoder inputs on one side,
// LED/tone driver and status outputs on the other.
interface simon_sequencer_if #(
    parameter int BTN_W = 2,
    parameter int LVL_W = 6
);
    logic             start;
    logic [BTN_W-1:0] player_num;
    logic             player_pressed;
    logic             simon_turn;
    logic [BTN_W-1:0] simon_num;
    logic             simon_pressed;
    logic [LVL_W-1:0] level;
    logic             game_over;
    logic             game_won;

    modport master (
        output start, player_num, player_pressed,
        input  simon_turn, simon_num, simon_pressed, level, game_over, game_won
    );

    modport slave (
        input  start, player_num, player_pressed,
        output simon_turn, simon_num, simon_pressed, level, game_over, game_won
    );
endinterface

// File: rtl/simon_sequencer.sv
// Simon game engine: grows an LFSR-derived button sequence one step per round, plays it
// back as timed pulses, then checks the player's repetition under a per-press timeout.
module simon_sequencer #(
    parameter int          BTN_W      = 2,
    parameter int          MAX_LEN    = 32,
    parameter int          ON_CYCLES  = 25_000_000,
    parameter int          OFF_CYCLES = 12_500_000,
    parameter int          TIMEOUT    = 250_000_000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic             clk,
    input logic             reset,
    simon_sequencer_if.slave bus
);
    localparam int LVL_W    = $clog2(MAX_LEN + 1);
    localparam int IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMR_PEAK = (ON_CYCLES > OFF_CYCLES)
                            ? ((ON_CYCLES  > TIMEOUT) ? ON_CYCLES  : TIMEOUT)
                            : ((OFF_CYCLES > TIMEOUT) ? OFF_CYCLES : TIMEOUT);
    localparam int TMR_W    = (TMR_PEAK > 1) ? $clog2(TMR_PEAK) : 1;

    localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [LVL_W-1:0] LEN_MAX  = LVL_W'(MAX_LEN);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] APPEND   = 3'd1;
    localparam logic [2:0] SHOW_ON  = 3'd2;
    localparam logic [2:0] SHOW_OFF = 3'd3;
    localparam logic [2:0] LISTEN   = 3'd4;
    localparam logic [2:0] OVER     = 3'd5;
    localparam logic [2:0] WON      = 3'd6;

    logic [2:0]       state_q,  state_d;
    logic [15:0]      lfsr_q,   lfsr_d;
    logic [LVL_W-1:0] len_q,    len_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [TMR_W-1:0] timer_q,  timer_d;
    logic             simon_turn_q,    simon_turn_d;
    logic [BTN_W-1:0] simon_num_q,     simon_num_d;
    logic             simon_pressed_q, simon_pressed_d;
    logic             game_over_q,     game_over_d;
    logic             game_won_q,      game_won_d;

    logic [BTN_W-1:0] seq_q [MAX_LEN];
    logic             seq_we_s;
    logic             idx_last_s;
    logic             press_ok_s;
    logic [BTN_W-1:0] seq_rd_s;

    assign idx_last_s = (LVL_W'(idx_q) == (len_q - LVL_W'(1)));
    assign press_ok_s = (bus.player_num == seq_q[idx_q]);

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        seq_we_s = 1'b0;
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        case (state_q)
            IDLE, OVER, WON: begin
                if (bus.start) begin
                    state_d = APPEND;
                    len_d   = {LVL_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            APPEND: begin
                seq_we_s = 1'b1;
                len_d    = len_q + LVL_W'(1);
                idx_d    = {IDX_W{1'b0}};
                timer_d  = {TMR_W{1'b0}};
                state_d  = SHOW_ON;
            end
            SHOW_ON: begin
                if (timer_q == ON_LAST) begin
                    timer_d = {TMR_W{1'b0}};
                    state_d = SHOW_OFF;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            SHOW_OFF: begin
                if (timer_q == OFF_LAST) begin
                    timer_d = {TMR_W{1'b0}};
                    if (idx_last_s) begin
                        idx_d   = {IDX_W{1'b0}};
                        state_d = LISTEN;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = SHOW_ON;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            LISTEN: begin
                // A press on the timeout cycle is judged on its merit, not as a timeout.
                if (bus.player_pressed) begin
                    if (!press_ok_s) begin
                        state_d = OVER;
                    end else if (!idx_last_s) begin
                        idx_d   = idx_q + IDX_W'(1);
                        timer_d = {TMR_W{1'b0}};
                    end else if (len_q == LEN_MAX) begin
                        state_d = WON;
                    end else begin
                        state_d = APPEND;
                    end
                end else if (timer_q == TO_LAST) begin
                    state_d = OVER;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The step written in APPEND is not in the array yet when SHOW_ON is entered.
        if ((state_q == APPEND) && (LVL_W'(idx_d) == len_q)) begin
            seq_rd_s = lfsr_q[BTN_W-1:0];
        end else begin
            seq_rd_s = seq_q[idx_d];
        end

        simon_turn_d    = (state_d == APPEND) || (state_d == SHOW_ON) || (state_d == SHOW_OFF);
        simon_pressed_d = (state_d == SHOW_ON);
        simon_num_d     = (state_d == SHOW_ON) ? seq_rd_s : {BTN_W{1'b0}};
        game_over_d     = (state_d == OVER);
        game_won_d      = (state_d == WON);
    end

    // Control state, LFSR and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            lfsr_q          <= LFSR_SEED;
            len_q           <= {LVL_W{1'b0}};
            idx_q           <= {IDX_W{1'b0}};
            timer_q         <= {TMR_W{1'b0}};
            simon_turn_q    <= 1'b0;
            simon_num_q     <= {BTN_W{1'b0}};
            simon_pressed_q <= 1'b0;
            game_over_q     <= 1'b0;
            game_won_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            lfsr_q          <= lfsr_d;
            len_q           <= len_d;
            idx_q           <= idx_d;
            timer_q         <= timer_d;
            simon_turn_q    <= simon_turn_d;
            simon_num_q     <= simon_num_d;
            simon_pressed_q <= simon_pressed_d;
            game_over_q     <= game_over_d;
            game_won_q      <= game_won_d;
        end
    end

    // Sequence storage; contents are meaningless until written by APPEND.
    always_ff @(posedge clk) begin
        if (seq_we_s) begin
            seq_q[IDX_W'(len_q)] <= lfsr_q[BTN_W-1:0];
        end
    end

    assign bus.simon_turn    = simon_turn_q;
    assign bus.simon_num     = simon_num_q;
    assign bus.simon_pressed = simon_pressed_q;
    assign bus.level         = len_q;
    assign bus.game_over     = game_over_q;
    assign bus.game_won      = game_won_q;
endmodule

// File: tb/tb_simon_sequencer.sv
// Self-checking bench for simon_sequencer with short timing parameters; expected
// playback comes from an independent LFSR model kept in lockstep with the DUT.
module tb_simon_sequencer;
    typedef struct packed {
        logic       turn;
        logic [1:0] num;
        logic       pressed;
        logic [1:0] level;
        logic       over;
        logic       won;
    } out_t;

    typedef struct {
        logic       st;
        logic [1:0] pn;
        logic       pp;
        out_t       exp;
    } vec_t;

    logic clk;
    logic reset;

    simon_sequencer_if #(.BTN_W(2), .LVL_W(2)) bus ();

    simon_sequencer #(
        .BTN_W(2), .MAX_LEN(3), .ON_CYCLES(4), .OFF_CYCLES(2), .TIMEOUT(10),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    out_t        sb_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] m_lfsr;
    logic [1:0]  seq_exp [3];

    function automatic out_t mk(input logic t, input logic [1:0] n, input logic p,
                                input logic [1:0] l, input logic o, input logic w);
        out_t r;
        r.turn = t; r.num = n; r.pressed = p; r.level = l; r.over = o; r.won = w;
        return r;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic out_t observe();
        return mk(bus.simon_turn, bus.simon_num, bus.simon_pressed, bus.level,
                  bus.game_over, bus.game_won);
    endfunction

    task automatic check(input string tag, input out_t got, input out_t want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got turn=%0b num=%0d pressed=%0b level=%0d over=%0b won=%0b, required turn=%0b num=%0d pressed=%0b level=%0d over=%0b won=%0b",
                     tag, got.turn, got.num, got.pressed, got.level, got.over, got.won,
                     want.turn, want.num, want.pressed, want.level, want.over, want.won);
        end
    endtask

    // One clock: drive inputs, queue the expected post-edge outputs, compare at negedge.
    task automatic step(input string tag, input logic st, input logic [1:0] pn,
                        input logic pp, input out_t want);
        out_t w;
        bus.start          = st;
        bus.player_num     = pn;
        bus.player_pressed = pp;
        sb_q.push_back(want);
        @(posedge clk);
        m_lfsr = lfsr_next(m_lfsr);
        @(negedge clk);
        bus.start          = 1'b0;
        bus.player_pressed = 1'b0;
        w = sb_q.pop_front();
        check(tag, observe(), w);
    endtask

    // Called during the APPEND cycle; steps through playback and lands in LISTEN.
    task automatic play_round(input int n, input logic ign);
        logic [1:0] lv;
        lv = 2'(n);
        seq_exp[n-1] = m_lfsr[1:0];
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 4; c++)
                step("show_on", ign, ~seq_exp[i], ign, mk(1'b1, seq_exp[i], 1'b1, lv, 1'b0, 1'b0));
            for (int c = 0; c < 2; c++)
                step("show_off", ign, ~seq_exp[i], ign, mk(1'b1, 2'd0, 1'b0, lv, 1'b0, 1'b0));
        end
        step("listen_entry", 1'b0, 2'd0, 1'b0, mk(1'b0, 2'd0, 1'b0, lv, 1'b0, 1'b0));
    endtask

    vec_t idle_tbl [8];

    initial begin
        out_t zero;
        zero = mk(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        idle_tbl[0] = '{st: 1'b0, pn: 2'd0, pp: 1'b0, exp: zero};
        idle_tbl[1] = '{st: 1'b0, pn: 2'd1, pp: 1'b1, exp: zero};
        idle_tbl[2] = '{st: 1'b0, pn: 2'd2, pp: 1'b1, exp: zero};
        idle_tbl[3] = '{st: 1'b0, pn: 2'd3, pp: 1'b0, exp: zero};
        idle_tbl[4] = '{st: 1'b0, pn: 2'd3, pp: 1'b1, exp: zero};
        idle_tbl[5] = '{st: 1'b0, pn: 2'd0, pp: 1'b1, exp: zero};
        idle_tbl[6] = '{st: 1'b0, pn: 2'd2, pp: 1'b0, exp: zero};
        idle_tbl[7] = '{st: 1'b0, pn: 2'd1, pp: 1'b0, exp: zero};

        reset              = 1'b0;
        bus.start          = 1'b0;
        bus.player_num     = 2'd0;
        bus.player_pressed = 1'b0;
        m_lfsr             = 16'hACE1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", observe(), zero);
        reset = 1'b1;

        // Idle: presses without start change nothing.
        for (int i = 0; i < 8; i++)
            step("idle_tbl", idle_tbl[i].st, idle_tbl[i].pn, idle_tbl[i].pp, idle_tbl[i].exp);
        for (int i = 0; i < 12; i++)
            step("idle", 1'b0, 2'd0, 1'b0, zero);

        // Full game won in three rounds.
        step("start", 1'b1, 2'd0, 1'b0, mk(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        play_round(1, 1'b0);
        step("listen_wait", 1'b0, 2'd0, 1'b0, mk(1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0));
        step("listen_wait", 1'b0, 2'd0, 1'b0, mk(1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0));
        step("r1_p0", 1'b0, seq_exp[0], 1'b1, mk(1'b1, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0));
        play_round(2, 1'b0);
        step("r2_p0", 1'b0, seq_exp[0], 1'b1, mk(1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0));
        step("r2_p1", 1'b0, seq_exp[1], 1'b1, mk(1'b1, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0));
        play_round(3, 1'b0);
        step("r3_p0", 1'b0, seq_exp[0], 1'b1, mk(1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0));
        step("r3_p1", 1'b0, seq_exp[1], 1'b1, mk(1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0));
        step("r3_win", 1'b0, seq_exp[2], 1'b1, mk(1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 1'b1));
        step("won_ignore", 1'b0, seq_exp[0], 1'b1, mk(1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 1'b1));
        step("won_hold", 1'b0, 2'd0, 1'b0, mk(1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 1'b1));

        // Wrong button in round 2.
        step("start2", 1'b1, 2'd0, 1'b0, mk(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        play_round(1, 1'b0);
        step("g2_r1", 1'b0, seq_exp[0], 1'b1, mk(1'b1, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0));
        play_round(2, 1'b0);
        step("g2_p0", 1'b0, seq_exp[0], 1'b1, mk(1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0));
        step("wrong", 1'b0, seq_exp[1] ^ 2'd1, 1'b1, mk(1'b0, 2'd0, 1'b0, 2'd2, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++)
            step("over_ignore", 1'b0, seq_exp[i % 2], 1'b1, mk(1'b0, 2'd0, 1'b0, 2'd2, 1'b1, 1'b0));

        // Timeout exactly 10 cycles after LISTEN entry.
        step("start3", 1'b1, 2'd0, 1'b0, mk(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        play_round(1, 1'b0);
        for (int i = 0; i < 9; i++)
            step("pre_timeout", 1'b0, 2'd0, 1'b0, mk(1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0));
        step("timeout", 1'b0, 2'd0, 1'b0, mk(1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0));

        // Press on the timeout cycle wins; then ignored inputs during playback.
        step("start4", 1'b1, 2'd0, 1'b0, mk(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        play_round(1, 1'b0);
        for (int i = 0; i < 9; i++)
            step("pre_late", 1'b0, 2'd0, 1'b0, mk(1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0));
        step("late_press", 1'b0, seq_exp[0], 1'b1, mk(1'b1, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0));
        play_round(2, 1'b1);
        step("g4_p0", 1'b0, seq_exp[0], 1'b1, mk(1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0));
        step("g4_p1", 1'b0, seq_exp[1], 1'b1, mk(1'b1, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0));
        seq_exp[2] = m_lfsr[1:0];
        step("g4_show", 1'b0, 2'd0, 1'b0, mk(1'b1, seq_exp[0], 1'b1, 2'd3, 1'b0, 1'b0));

        // Reset in the middle of SHOW_ON clears outputs without waiting for a clock.
        #2 reset = 1'b0;
        #1 check("reset_mid", observe(), zero);
        @(posedge clk);
        @(negedge clk);
        check("reset_hold", observe(), zero);
        reset  = 1'b1;
        m_lfsr = 16'hACE1;
        step("start5", 1'b1, 2'd0, 1'b0, mk(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        play_round(1, 1'b0);
        step("g5_r1", 1'b0, seq_exp[0], 1'b1, mk(1'b1, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
